// File: rtl/rflp_sram_ctrl_if.sv
// rtl/rflp_sram_ctrl_if.sv - request/response/clear bundle between datapath and rflp_sram_ctrl
//
// Purpose : groups the controller's handshake signals so they travel as one port.
// Signals : REQ_VALID/REQ_READY/REQ_WR/REQ_ADDR/REQ_WDATA  single-word request channel
//           RSP_VALID/RSP_RDATA                            read response channel (no backpressure)
//           CLR_REQ                                        one-cycle pulse starting a fill sweep
//           INIT_DONE                                      high while no sweep is active
// Modports: master = datapath side, slave = controller side.
interface rflp_sram_ctrl_if #(
  parameter int DW = 26,
  parameter int AW = 8
);
  logic          REQ_VALID;
  logic          REQ_READY;
  logic          REQ_WR;
  logic [AW-1:0] REQ_ADDR;
  logic [DW-1:0] REQ_WDATA;
  logic          RSP_VALID;
  logic [DW-1:0] RSP_RDATA;
  logic          CLR_REQ;
  logic          INIT_DONE;

  modport master (
    output REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, CLR_REQ,
    input  REQ_READY, RSP_VALID, RSP_RDATA, INIT_DONE
  );

  modport slave (
    input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, CLR_REQ,
    output REQ_READY, RSP_VALID, RSP_RDATA, INIT_DONE
  );
endinterface

// File: rtl/rflp_sram_ctrl.sv
// rtl/rflp_sram_ctrl.sv - initiator-side controller for the 256x26 register-file SRAM macro
//
// Purpose : services single-word read/write requests against the macro, and sweeps every
//           word to FILL after reset and on CLR_REQ before accepting requests.
// Ports   : CLK, RST       clock (rising edge) and asynchronous active-high reset
//           bus (slave)    request/response/clear handshake, see rflp_sram_ctrl_if
//           NCE, NWRT      macro chip enable / write enable, active low
//           RA, CA         macro row / column address, {RA,CA} = word address
//           DIN            macro write data
//           DO             macro read data, valid shortly after the edge that sampled the read
module rflp_sram_ctrl #(
  parameter int            DW   = 26,
  parameter int            AW   = 8,
  parameter int            CAW  = 2,
  parameter logic [DW-1:0] FILL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  rflp_sram_ctrl_if.slave   bus,
  output logic              NCE,
  output logic              NWRT,
  output logic [AW-CAW-1:0] RA,
  output logic [CAW-1:0]    CA,
  output logic [DW-1:0]     DIN,
  input  logic [DW-1:0]     DO
);

  typedef enum logic {
    S_CLR = 1'b0,
    S_RUN = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic          nce_q;
  logic          nwrt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [1:0]    rd_pipe;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;
  logic          req_ready_q;
  logic          init_done_q;
  logic          acc;

  // REQ_READY is only ever high in RUN, so it alone qualifies acceptance.
  assign acc = bus.REQ_VALID && req_ready_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_CLR;
      cnt         <= '0;
      nce_q       <= 1'b1;
      nwrt_q      <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      rd_pipe     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      // Read pipeline runs regardless of state so reads issued just before a
      // clear still return: stage 0 = pins driven, stage 1 = DO valid next edge.
      rd_pipe     <= {rd_pipe[0], acc && !bus.REQ_WR};
      rsp_valid_q <= rd_pipe[1];
      if (rd_pipe[1]) begin
        rsp_rdata_q <= DO;
      end
      nce_q  <= 1'b1;
      nwrt_q <= 1'b1;
      case (state)
        S_CLR: begin
          nce_q  <= 1'b0;
          nwrt_q <= 1'b0;
          addr_q <= cnt;
          din_q  <= FILL;
          // The edge that issues the last write also opens the request port,
          // so the sweep occupies exactly 2^AW cycles and never wraps.
          if (cnt == '1) begin
            state       <= S_RUN;
            req_ready_q <= 1'b1;
            init_done_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (acc) begin
            nce_q  <= 1'b0;
            nwrt_q <= ~bus.REQ_WR;
            addr_q <= bus.REQ_ADDR;
            if (bus.REQ_WR) begin
              din_q <= bus.REQ_WDATA;
            end
          end
          // A request accepted on this same edge has already been issued above.
          if (bus.CLR_REQ) begin
            state       <= S_CLR;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            cnt         <= '0;
          end
        end
        default: state <= S_CLR;
      endcase
    end
  end

  assign NCE           = nce_q;
  assign NWRT          = nwrt_q;
  assign RA            = addr_q[AW-1:CAW];
  assign CA            = addr_q[CAW-1:0];
  assign DIN           = din_q;
  assign bus.REQ_READY = req_ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.INIT_DONE = init_done_q;

endmodule
